// File: rtl/prio_arbiter.sv
// Grant arbiter for N requesters sharing one resource: fixed-priority or round-robin
// selection (highest index first), grant held until done, holder withdrawal or tenure limit.
module prio_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 done,
  input  logic                 mode,
  output logic [N-1:0]         grant,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 timeout
);

  localparam int IDW = $clog2(N);
  // A zero-width counter is illegal, so an unlimited tenure still keeps one bit.
  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         state, state_n;
  logic [N-1:0]   grant_n;
  logic           grant_valid_n;
  logic [IDW-1:0] grant_id_n;
  logic           timeout_n;
  logic [IDW-1:0] last_id, last_id_n;
  logic [HCW-1:0] hold_cnt, hold_cnt_n;

  logic [N-1:0]   rr_mask;
  logic [N-1:0]   req_low;
  logic [IDW-1:0] winner;
  logic           hold_exp;
  logic           holder_req;
  logic           release_any;

  // Index of the highest set bit; the caller guarantees v is nonzero.
  function automatic logic [IDW-1:0] highest(input logic [N-1:0] v);
    highest = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) highest = IDW'(i);
    end
  endfunction

  // Round-robin walks k-1..0 first, then N-1..k. Requesters below last_id form the
  // preferred group; if none of them asks, plain highest-first over all of req
  // lands in N-1..k. With last_id = 0 the mask is empty and this reduces to fixed priority.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      rr_mask[i] = (IDW'(i) < last_id);
    end
    req_low = req & rr_mask;
    if (mode && (req_low != '0)) winner = highest(req_low);
    else                         winner = highest(req);
  end

  always_comb begin
    hold_exp    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
    holder_req  = req[grant_id];
    release_any = done || !holder_req || hold_exp;
  end

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    state_n       = state;
    grant_n       = grant;
    grant_valid_n = grant_valid;
    grant_id_n    = grant_id;
    last_id_n     = last_id;
    hold_cnt_n    = hold_cnt;
    timeout_n     = 1'b0;

    unique case (state)
      IDLE: begin
        if (req != '0) begin
          state_n          = BUSY;
          grant_n          = '0;
          grant_n[winner]  = 1'b1;
          grant_valid_n    = 1'b1;
          grant_id_n       = winner;
          last_id_n        = winner;
          hold_cnt_n       = '0;
        end
      end
      BUSY: begin
        if (release_any) begin
          state_n       = IDLE;
          grant_n       = '0;
          grant_valid_n = 1'b0;
          grant_id_n    = '0;
          // A coincident done or withdrawal makes this an ordinary release.
          timeout_n     = hold_exp && !done && holder_req;
        end else if (hold_cnt != '1) begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      timeout     <= 1'b0;
      last_id     <= '0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      grant_valid <= grant_valid_n;
      grant_id    <= grant_id_n;
      timeout     <= timeout_n;
      last_id     <= last_id_n;
      hold_cnt    <= hold_cnt_n;
    end
  end

endmodule

// File: doc/prio_arbiter.md
# prio_arbiter

Arbiter that shares one downstream resource among 8 requesters using one-hot, highest-index-first priority selection. It runs in either fixed-priority mode or round-robin mode. It holds each grant until the holder releases it or a tenure limit expires, and it sits between the requester bank and the shared resource's single access port.

## Interface
- `N`, default 8: number of requesters; the design is verified at 8 only.
- `MAX_HOLD`, default 16: maximum grant tenure in cycles. 0 means unlimited (timeout disabled).
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `req`  in  N  per-requester request level; bit i high means requester i wants the resource.
- `done`  in  1  one-cycle pulse from the resource ending the current transaction; ignored when no grant is active.
- `mode`  in  1  0 = fixed priority (index N-1 highest), 1 = round-robin.
- `grant`  out  N  registered, one-hot or all-zero grant vector.
- `grant_valid`  out  1  high exactly when `grant` is nonzero.
- `grant_id`  out  $clog2(N)  binary index of the granted bit; 0 when `grant_valid` = 0.
- `timeout`  out  1  one-cycle pulse: the grant was revoked by the tenure limit.

## Operation
- FSM states:
  - IDLE: no grant. `grant` = 0.
  - BUSY: exactly one bit of `grant` set.
- IDLE transition:
  - If `req` != 0, a winner is selected combinationally from `req` and the priority order.
  - At the next edge: `grant` = one-hot(winner), `grant_id` = winner, `hold_cnt` = 0, `last_id` = winner, state -> BUSY.
  - If `req` = 0, stay in IDLE.
- Fixed-priority order: N-1, N-2, ..., 0. The highest set bit wins; all lower bits are masked.
- Round-robin order: k-1, k-2, ..., 0, N-1, ..., k, where k = `last_id`.
  - The most recent winner becomes lowest priority.
  - With `last_id` = 0 (reset value), this order equals the fixed-priority order.
- `last_id` updates on every grant in both modes.
- `mode` is sampled only during IDLE arbitration. Changing it during BUSY has no effect on the current grant.
- BUSY release conditions, evaluated at each edge; any one returns the FSM to IDLE with `grant` = 0:
  - `done` = 1;
  - `req[grant_id]` = 0 (holder withdrew);
  - `MAX_HOLD` != 0 and `hold_cnt` == `MAX_HOLD`-1 (timeout).
- If none of the release conditions holds, `hold_cnt` increments. `hold_cnt` width is $clog2(MAX_HOLD+1) and it never wraps.
- `timeout` is registered: it is 1 for exactly the first IDLE cycle after a timeout release, and 0 otherwise.
- Simultaneous release causes: if `done` or holder withdrawal coincides with the timeout edge, the release counts as normal and `timeout` stays 0.
- Requests from non-holders during BUSY are not queued or latched. They are sampled again in the next IDLE cycle.
- No preemption: a higher-priority request arriving during BUSY does not revoke the current grant.

## Timing
- Reset (`rst_n` low, asynchronous, effective without a clock edge):
  - `grant` = 0, `grant_valid` = 0, `grant_id` = 0, `timeout` = 0;
  - `last_id` = 0, `hold_cnt` = 0, state = IDLE.
- Reset asserted mid-BUSY drops the grant immediately; the in-flight transaction is the resource's problem.
- First arbitration occurs at the first rising edge after `rst_n` rises while `req` != 0.
- Request to grant latency: 1 cycle. `req` seen high in IDLE at edge t-1 gives `grant` valid after edge t.
- Release to next grant: one dead cycle (IDLE) is always inserted between tenures, so back-to-back grants are 1 cycle apart at minimum.
- With `MAX_HOLD` = M, a never-releasing holder keeps `grant` high for exactly M cycles. `timeout` pulses in the cycle after the last granted cycle.
- All outputs are driven directly from flops; no combinational path from inputs to outputs.

## Test plan
- Fixed-priority mode: `mode`=0, `req`=8'b0010_0101 held. After edge 1, `grant`=8'b0010_0000 and `grant_id`=5. Pulse `done`: the next cycle has `grant`=0; the following cycle has `grant`=8'b0010_0000 again (5 still highest).
- Round-robin mode: `mode`=1, `req`=8'hFF held, `done` pulsed in the first cycle of each grant. The `grant_id` sequence is 7,6,5,4,3,2,1,0,7, with one zero-`grant` cycle between each.
- Tenure limit: `MAX_HOLD`=16, only `req[3]` held, `done`=0. `grant`=8'b0000_1000 for exactly 16 cycles, then one cycle with `grant`=0 and `timeout`=1, then `req[3]` is granted again with `timeout`=0.
- Simultaneous release: `done`=1 exactly on the 16th granted cycle. `grant` drops and `timeout` stays 0. Separately, dropping `req[grant_id]` mid-tenure with `req[1]` pending: `grant` = 0 for 1 cycle, then `grant_id`=1.
- Asynchronous reset: assert `rst_n`=0 between clock edges during BUSY with `grant_id`=4. All outputs go to 0 before the next edge. After release with `req`=8'hFF in round-robin mode, the first `grant_id` is 7.
- No preemption: `req[0]` is granted, then `req[7]` rises during BUSY. `grant` stays 8'b0000_0001 until `done`; after the dead cycle, `grant_id`=7.
